// File: rtl/music_sequencer_pkg.sv
// Shared types for the music sequencer: transport states and direction encoding.
package music_sequencer_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    FETCH   = 2'd1,
    LOAD    = 2'd2,
    PLAYING = 2'd3
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/music_sequencer_tempo_controller.sv
// Saturating cycles-per-note register driven by rotary detents, with a tempo reset.
module tempo_controller #(
  parameter int          CPN_WIDTH   = 25,
  parameter int unsigned CPN_DEFAULT = 5000000,
  parameter int unsigned CPN_STEP    = 250000,
  parameter int unsigned CPN_MIN     = 500000,
  parameter int unsigned CPN_MAX     = 20000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rotary_event,
  input  logic                 rotary_left,
  input  logic                 tempo_reset,
  output logic [CPN_WIDTH-1:0] cpn,
  output logic                 at_default
);

  localparam logic [CPN_WIDTH:0] DEF_W  = (CPN_WIDTH+1)'(CPN_DEFAULT);
  localparam logic [CPN_WIDTH:0] STEP_W = (CPN_WIDTH+1)'(CPN_STEP);
  localparam logic [CPN_WIDTH:0] MIN_W  = (CPN_WIDTH+1)'(CPN_MIN);
  localparam logic [CPN_WIDTH:0] MAX_W  = (CPN_WIDTH+1)'(CPN_MAX);

  logic [CPN_WIDTH-1:0] r_cpn;
  logic                 r_at_default;
  logic [CPN_WIDTH:0]   w_cpn_ext;
  logic [CPN_WIDTH:0]   w_up;
  logic [CPN_WIDTH:0]   w_dn;
  logic [CPN_WIDTH:0]   w_next;

  // One extra bit keeps both the sum and the difference from wrapping.
  always_comb begin
    w_cpn_ext = {1'b0, r_cpn};
    w_up      = w_cpn_ext + STEP_W;
    if (w_up > MAX_W) w_up = MAX_W;
    w_dn = (w_cpn_ext < MIN_W + STEP_W) ? MIN_W : w_cpn_ext - STEP_W;
    w_next = w_cpn_ext;
    if (tempo_reset)       w_next = DEF_W;
    else if (rotary_event) w_next = rotary_left ? w_up : w_dn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpn        <= CPN_WIDTH'(CPN_DEFAULT);
      r_at_default <= 1'b1;
    end else begin
      r_cpn        <= w_next[CPN_WIDTH-1:0];
      r_at_default <= (w_next == DEF_W);
    end
  end

  assign cpn        = r_cpn;
  assign at_default = r_at_default;

endmodule

// File: rtl/music_sequencer.sv
// Tone ROM walker: play/pause, direction, loop and tempo control feeding the piezo tone generator.
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int          TONE_WIDTH  = 24,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          LAST_ADDR   = 1023,
  parameter int          CPN_WIDTH   = 25,
  parameter int unsigned CPN_DEFAULT = 5000000,
  parameter int unsigned CPN_STEP    = 250000,
  parameter int unsigned CPN_MIN     = 500000,
  parameter int unsigned CPN_MAX     = 20000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rotary_event,
  input  logic                  rotary_left,
  input  logic                  rotary_push,
  input  logic                  button_center,
  input  logic                  button_east,
  input  logic                  button_west,
  input  logic                  button_south,
  input  logic                  button_north,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [TONE_WIDTH-1:0] rom_data,
  output logic [TONE_WIDTH-1:0] tone,
  output logic                  led_center,
  output logic                  led_east,
  output logic                  led_west,
  output logic                  led_south,
  output logic                  led_north,
  output logic [7:0]            GPIO_leds,
  output state_t                dbg_state,
  output logic [CPN_WIDTH-1:0]  dbg_cpn
);

  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CPN_WIDTH-1:0]  r_note_cnt;
  logic [TONE_WIDTH-1:0] r_tone;
  logic                  r_dir;
  logic                  r_loop;
  logic                  r_led_center;
  logic                  r_led_east;
  logic [CPN_WIDTH-1:0]  w_cpn;
  logic                  w_at_default;
  logic                  w_dir_next;
  logic                  w_note_done;

  tempo_controller #(
    .CPN_WIDTH  (CPN_WIDTH),
    .CPN_DEFAULT(CPN_DEFAULT),
    .CPN_STEP   (CPN_STEP),
    .CPN_MIN    (CPN_MIN),
    .CPN_MAX    (CPN_MAX)
  ) u_tempo (
    .clk         (clk),
    .rst         (rst),
    .rotary_event(rotary_event),
    .rotary_left (rotary_left),
    .tempo_reset (button_north),
    .cpn         (w_cpn),
    .at_default  (w_at_default)
  );

  // East and west together cancel out and leave the direction alone.
  always_comb begin
    w_dir_next = r_dir;
    if (button_east && !button_west)      w_dir_next = DIR_FWD;
    else if (button_west && !button_east) w_dir_next = DIR_REV;
  end

  assign w_note_done = (r_note_cnt >= (w_cpn - CPN_WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= PAUSED;
      r_addr       <= '0;
      r_note_cnt   <= '0;
      r_tone       <= '0;
      r_dir        <= DIR_FWD;
      r_loop       <= 1'b1;
      r_led_center <= 1'b0;
      r_led_east   <= 1'b1;
    end else begin
      r_dir      <= w_dir_next;
      r_led_east <= (w_dir_next == DIR_FWD);
      r_loop     <= r_loop ^ button_south;
      if (rotary_push) begin
        r_addr     <= (r_dir == DIR_FWD) ? '0 : LAST_A;
        r_note_cnt <= '0;
        if (r_state != PAUSED) r_state <= FETCH;
      end else if (button_center && r_state != PAUSED) begin
        r_state      <= PAUSED;
        r_tone       <= '0;
        r_note_cnt   <= '0;
        r_led_center <= 1'b0;
      end else begin
        case (r_state)
          PAUSED: begin
            r_tone <= '0;
            if (button_center) begin
              r_state      <= FETCH;
              r_led_center <= 1'b1;
            end
          end
          FETCH: r_state <= LOAD;
          LOAD: begin
            r_tone     <= rom_data;
            r_note_cnt <= '0;
            r_state    <= PLAYING;
          end
          PLAYING: begin
            if (w_note_done) begin
              r_note_cnt <= '0;
              r_state    <= FETCH;
              // End of the song in the current direction: wrap, or stop when one-shot.
              if ((r_dir == DIR_FWD) ? (r_addr == LAST_A) : (r_addr == '0)) begin
                r_addr <= (r_dir == DIR_FWD) ? '0 : LAST_A;
                if (!r_loop) begin
                  r_state      <= PAUSED;
                  r_tone       <= '0;
                  r_led_center <= 1'b0;
                end
              end else begin
                r_addr <= (r_dir == DIR_FWD) ? r_addr + ADDR_WIDTH'(1) : r_addr - ADDR_WIDTH'(1);
              end
            end else begin
              r_note_cnt <= r_note_cnt + CPN_WIDTH'(1);
            end
          end
          default: r_state <= PAUSED;
        endcase
      end
    end
  end

  assign rom_addr   = r_addr;
  assign tone       = r_tone;
  assign led_center = r_led_center;
  assign led_east   = r_led_east;
  assign led_west   = r_dir;
  assign led_south  = r_loop;
  assign led_north  = w_at_default;
  assign GPIO_leds  = r_addr[ADDR_WIDTH-1 -: 8];
  assign dbg_state  = r_state;
  assign dbg_cpn    = w_cpn;

endmodule
